axi_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single 64-bit AXI memory master port of the core top level between `NumMst` AXI requesters, for example two cores, or a core plus a debug/DMA master. Read and write address channels are arbitrated independently. Write data is steered by a write-burst lock. B and R responses are routed back by a master-index field that the arbiter prepends to the transaction ID. The block sits between the requesters and the flattened `io_axi_mem_*` boundary.

---
 rtl/axi_mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
//
// Shares one AXI memory master port between NumMst requesters. AR and AW are
// arbitrated independently with round-robin pointers. After an AW is accepted,
// the W channel is locked to that requester until its last beat. Downstream IDs
// carry the requester index in their MSBs. B and R responses are routed back by
// that index, and the index is stripped before the ID reaches the requester.
// All channels are combinational pass-throughs. The only state is the two
// arbiter FSMs, their latched grants, the round-robin pointers and the W owner.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_aw_* / s_w_* / s_b_*  per-requester write channels (requester 0 in LSBs)
//   s_ar_* / s_r_*          per-requester read channels
//   m_aw_* / m_w_* / m_b_*  downstream write channels, ID width IdWidth+IxW
//   m_ar_* / m_r_*          downstream read channels
// ---------------------------------------------------------------------------
module axi_mem_arbiter #(
   parameter int  NumMst    = 2,
   parameter int  IdWidth   = 4,
   parameter int  AddrWidth = 64,
   parameter int  DataWidth = 64,
   localparam int IxW       = $clog2(NumMst),
   localparam int StrbW     = DataWidth / 8,
   localparam int AttrW     = 17,
   localparam int MIdW      = IdWidth + IxW
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   // requester write address
   input  logic [NumMst-1:0]              s_aw_valid_i,
   output logic [NumMst-1:0]              s_aw_ready_o,
   input  logic [NumMst*IdWidth-1:0]      s_aw_id_i,
   input  logic [NumMst*AddrWidth-1:0]    s_aw_addr_i,
   input  logic [NumMst*8-1:0]            s_aw_len_i,
   input  logic [NumMst*AttrW-1:0]        s_aw_attr_i,
   // requester write data
   input  logic [NumMst-1:0]              s_w_valid_i,
   output logic [NumMst-1:0]              s_w_ready_o,
   input  logic [NumMst*DataWidth-1:0]    s_w_data_i,
   input  logic [NumMst*StrbW-1:0]        s_w_strb_i,
   input  logic [NumMst-1:0]              s_w_last_i,
   // requester write response
   output logic [NumMst-1:0]              s_b_valid_o,
   input  logic [NumMst-1:0]              s_b_ready_i,
   output logic [IdWidth-1:0]             s_b_id_o,
   output logic [1:0]                     s_b_resp_o,
   // requester read address
   input  logic [NumMst-1:0]              s_ar_valid_i,
   output logic [NumMst-1:0]              s_ar_ready_o,
   input  logic [NumMst*IdWidth-1:0]      s_ar_id_i,
   input  logic [NumMst*AddrWidth-1:0]    s_ar_addr_i,
   input  logic [NumMst*8-1:0]            s_ar_len_i,
   input  logic [NumMst*AttrW-1:0]        s_ar_attr_i,
   // requester read data
   output logic [NumMst-1:0]              s_r_valid_o,
   input  logic [NumMst-1:0]              s_r_ready_i,
   output logic [IdWidth-1:0]             s_r_id_o,
   output logic [DataWidth-1:0]           s_r_data_o,
   output logic [1:0]                     s_r_resp_o,
   output logic                           s_r_last_o,
   // downstream write address
   output logic                           m_aw_valid_o,
   input  logic                           m_aw_ready_i,
   output logic [MIdW-1:0]                m_aw_id_o,
   output logic [AddrWidth-1:0]           m_aw_addr_o,
   output logic [7:0]                     m_aw_len_o,
   output logic [AttrW-1:0]               m_aw_attr_o,
   // downstream write data
   output logic                           m_w_valid_o,
   input  logic                           m_w_ready_i,
   output logic [DataWidth-1:0]           m_w_data_o,
   output logic [StrbW-1:0]               m_w_strb_o,
   output logic                           m_w_last_o,
   // downstream write response
   input  logic                           m_b_valid_i,
   output logic                           m_b_ready_o,
   input  logic [MIdW-1:0]                m_b_id_i,
   input  logic [1:0]                     m_b_resp_i,
   // downstream read address
   output logic                           m_ar_valid_o,
   input  logic                           m_ar_ready_i,
   output logic [MIdW-1:0]                m_ar_id_o,
   output logic [AddrWidth-1:0]           m_ar_addr_o,
   output logic [7:0]                     m_ar_len_o,
   output logic [AttrW-1:0]               m_ar_attr_o,
   // downstream read data
   input  logic                           m_r_valid_i,
   output logic                           m_r_ready_o,
   input  logic [MIdW-1:0]                m_r_id_i,
   input  logic [DataWidth-1:0]           m_r_data_i,
   input  logic [1:0]                     m_r_resp_i,
   input  logic                           m_r_last_i
);

   typedef enum logic {AR_IDLE, AR_HOLD} ar_state_e;
   typedef enum logic [1:0] {AW_IDLE, AW_HOLD, W_BURST} aw_state_e;

   ar_state_e        ar_state_q, ar_state_d;
   aw_state_e        aw_state_q, aw_state_d;
   logic [IxW-1:0]   ar_grant_q, ar_grant_d;
   logic [IxW-1:0]   aw_grant_q, aw_grant_d;
   logic [IxW-1:0]   rr_ar_q, rr_ar_d;
   logic [IxW-1:0]   rr_aw_q, rr_aw_d;
   logic [IxW-1:0]   w_owner_q, w_owner_d;

   logic [IxW-1:0]   ar_sel, aw_sel, r_tag, b_tag;
   logic             ar_valid, ar_hs, aw_valid, aw_hs, w_valid, w_hs;

   // First requesting index at or after ptr, wrapping. Because NumMst is a
   // power of two, IxW-bit addition wraps naturally. If nobody requests,
   // ptr is returned, and its valid bit is 0.
   function automatic logic [IxW-1:0] rr_pick(input logic [NumMst-1:0] req,
                                              input logic [IxW-1:0]    ptr);
      logic [IxW-1:0] idx;
      logic           found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < NumMst; k++) begin
         idx = ptr + IxW'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Read address arbiter. In HOLD the latched grant is forwarded, so the
   // pending payload never changes before the handshake.
   always_comb begin
      ar_state_d = ar_state_q;
      ar_grant_d = ar_grant_q;
      rr_ar_d    = rr_ar_q;
      ar_sel     = (ar_state_q == AR_HOLD) ? ar_grant_q : rr_pick(s_ar_valid_i, rr_ar_q);
      ar_valid   = s_ar_valid_i[ar_sel] && !rst_i;
      ar_hs      = ar_valid && m_ar_ready_i;
      if (ar_hs) begin
         ar_state_d = AR_IDLE;
         rr_ar_d    = ar_sel + IxW'(1);
      end else if (ar_valid) begin
         ar_state_d = AR_HOLD;
         ar_grant_d = ar_sel;
      end
   end

   // Write address arbiter plus the W lock. The AW handshake hands the W
   // channel to the winner until its last beat, and AW stays blocked meanwhile.
   always_comb begin
      aw_state_d = aw_state_q;
      aw_grant_d = aw_grant_q;
      rr_aw_d    = rr_aw_q;
      w_owner_d  = w_owner_q;
      aw_sel     = (aw_state_q == AW_HOLD) ? aw_grant_q : rr_pick(s_aw_valid_i, rr_aw_q);
      aw_valid   = (aw_state_q != W_BURST) && s_aw_valid_i[aw_sel] && !rst_i;
      aw_hs      = aw_valid && m_aw_ready_i;
      w_valid    = (aw_state_q == W_BURST) && s_w_valid_i[w_owner_q] && !rst_i;
      w_hs       = w_valid && m_w_ready_i;
      if (aw_hs) begin
         aw_state_d = W_BURST;
         w_owner_d  = aw_sel;
         rr_aw_d    = aw_sel + IxW'(1);
      end else if (aw_valid) begin
         aw_state_d = AW_HOLD;
         aw_grant_d = aw_sel;
      end else if (w_hs && s_w_last_i[w_owner_q]) begin
         aw_state_d = AW_IDLE;
      end
   end

   // Channel steering. Every valid and ready is qualified by !rst_i, so
   // asserting reset silences the whole boundary immediately.
   always_comb begin
      m_ar_valid_o = ar_valid;
      m_ar_id_o    = {ar_sel, s_ar_id_i[int'(ar_sel)*IdWidth +: IdWidth]};
      m_ar_addr_o  = s_ar_addr_i[int'(ar_sel)*AddrWidth +: AddrWidth];
      m_ar_len_o   = s_ar_len_i[int'(ar_sel)*8 +: 8];
      m_ar_attr_o  = s_ar_attr_i[int'(ar_sel)*AttrW +: AttrW];
      s_ar_ready_o = '0;
      s_ar_ready_o[ar_sel] = ar_valid && m_ar_ready_i;

      m_aw_valid_o = aw_valid;
      m_aw_id_o    = {aw_sel, s_aw_id_i[int'(aw_sel)*IdWidth +: IdWidth]};
      m_aw_addr_o  = s_aw_addr_i[int'(aw_sel)*AddrWidth +: AddrWidth];
      m_aw_len_o   = s_aw_len_i[int'(aw_sel)*8 +: 8];
      m_aw_attr_o  = s_aw_attr_i[int'(aw_sel)*AttrW +: AttrW];
      s_aw_ready_o = '0;
      s_aw_ready_o[aw_sel] = aw_valid && m_aw_ready_i;

      m_w_valid_o  = w_valid;
      m_w_data_o   = s_w_data_i[int'(w_owner_q)*DataWidth +: DataWidth];
      m_w_strb_o   = s_w_strb_i[int'(w_owner_q)*StrbW +: StrbW];
      m_w_last_o   = s_w_last_i[w_owner_q];
      s_w_ready_o  = '0;
      s_w_ready_o[w_owner_q] = (aw_state_q == W_BURST) && m_w_ready_i && !rst_i;

      r_tag        = m_r_id_i[MIdW-1:IdWidth];
      s_r_valid_o  = '0;
      s_r_valid_o[r_tag] = m_r_valid_i && !rst_i;
      m_r_ready_o  = s_r_ready_i[r_tag] && !rst_i;
      s_r_id_o     = m_r_id_i[IdWidth-1:0];
      s_r_data_o   = m_r_data_i;
      s_r_resp_o   = m_r_resp_i;
      s_r_last_o   = m_r_last_i;

      b_tag        = m_b_id_i[MIdW-1:IdWidth];
      s_b_valid_o  = '0;
      s_b_valid_o[b_tag] = m_b_valid_i && !rst_i;
      m_b_ready_o  = s_b_ready_i[b_tag] && !rst_i;
      s_b_id_o     = m_b_id_i[IdWidth-1:0];
      s_b_resp_o   = m_b_resp_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ar_state_q <= AR_IDLE;
         aw_state_q <= AW_IDLE;
         ar_grant_q <= '0;
         aw_grant_q <= '0;
         rr_ar_q    <= '0;
         rr_aw_q    <= '0;
         w_owner_q  <= '0;
      end else begin
         ar_state_q <= ar_state_d;
         aw_state_q <= aw_state_d;
         ar_grant_q <= ar_grant_d;
         aw_grant_q <= aw_grant_d;
         rr_ar_q    <= rr_ar_d;
         rr_aw_q    <= rr_aw_d;
         w_owner_q  <= w_owner_d;
      end
   end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Testbench for axi_mem_arbiter. Directed scenarios run first: reset, AR
// alternation, AR hold, response routing and reset in the middle of a burst.
// A long randomized run follows, checked against a transaction-level model
// that uses integer grant bookkeeping.
module tb_axi_mem_arbiter;
   localparam int NumMst = 2, IdWidth = 4, AddrWidth = 64, DataWidth = 64;
   localparam int IxW = 1, StrbW = 8, AttrW = 17, MIdW = IdWidth + IxW;

   logic clk_i = 1'b0, rst_i;
   always #5 clk_i = ~clk_i;

   logic [NumMst-1:0] s_aw_valid_i, s_aw_ready_o, s_w_valid_i, s_w_ready_o, s_w_last_i;
   logic [NumMst-1:0] s_b_valid_o, s_b_ready_i, s_ar_valid_i, s_ar_ready_o, s_r_valid_o, s_r_ready_i;
   logic [NumMst*IdWidth-1:0] s_aw_id_i, s_ar_id_i;
   logic [NumMst*AddrWidth-1:0] s_aw_addr_i, s_ar_addr_i;
   logic [NumMst*8-1:0] s_aw_len_i, s_ar_len_i;
   logic [NumMst*AttrW-1:0] s_aw_attr_i, s_ar_attr_i;
   logic [NumMst*DataWidth-1:0] s_w_data_i;
   logic [NumMst*StrbW-1:0] s_w_strb_i;
   logic [IdWidth-1:0] s_b_id_o, s_r_id_o;
   logic [1:0] s_b_resp_o, s_r_resp_o, m_b_resp_i, m_r_resp_i;
   logic [DataWidth-1:0] s_r_data_o, m_w_data_o, m_r_data_i;
   logic s_r_last_o, m_aw_valid_o, m_aw_ready_i, m_w_valid_o, m_w_ready_i, m_w_last_o;
   logic m_b_valid_i, m_b_ready_o, m_ar_valid_o, m_ar_ready_i, m_r_valid_i, m_r_ready_o, m_r_last_i;
   logic [MIdW-1:0] m_aw_id_o, m_ar_id_o, m_b_id_i, m_r_id_i;
   logic [AddrWidth-1:0] m_aw_addr_o, m_ar_addr_o;
   logic [7:0] m_aw_len_o, m_ar_len_o;
   logic [AttrW-1:0] m_aw_attr_o, m_ar_attr_o;
   logic [StrbW-1:0] m_w_strb_o;

   axi_mem_arbiter #(.NumMst(NumMst), .IdWidth(IdWidth), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o), .s_aw_id_i(s_aw_id_i),
      .s_aw_addr_i(s_aw_addr_i), .s_aw_len_i(s_aw_len_i), .s_aw_attr_i(s_aw_attr_i),
      .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o), .s_w_data_i(s_w_data_i),
      .s_w_strb_i(s_w_strb_i), .s_w_last_i(s_w_last_i),
      .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i), .s_b_id_o(s_b_id_o), .s_b_resp_o(s_b_resp_o),
      .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o), .s_ar_id_i(s_ar_id_i),
      .s_ar_addr_i(s_ar_addr_i), .s_ar_len_i(s_ar_len_i), .s_ar_attr_i(s_ar_attr_i),
      .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i), .s_r_id_o(s_r_id_o),
      .s_r_data_o(s_r_data_o), .s_r_resp_o(s_r_resp_o), .s_r_last_o(s_r_last_o),
      .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i), .m_aw_id_o(m_aw_id_o),
      .m_aw_addr_o(m_aw_addr_o), .m_aw_len_o(m_aw_len_o), .m_aw_attr_o(m_aw_attr_o),
      .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_data_o(m_w_data_o),
      .m_w_strb_o(m_w_strb_o), .m_w_last_o(m_w_last_o),
      .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o), .m_b_id_i(m_b_id_i), .m_b_resp_i(m_b_resp_i),
      .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i), .m_ar_id_o(m_ar_id_o),
      .m_ar_addr_o(m_ar_addr_o), .m_ar_len_o(m_ar_len_o), .m_ar_attr_o(m_ar_attr_o),
      .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_id_i(m_r_id_i),
      .m_r_data_i(m_r_data_i), .m_r_resp_i(m_r_resp_i), .m_r_last_i(m_r_last_i));

   // Requester-side driver state. A raised valid is held until the model
   // sees its handshake, so payloads stay AXI-stable.
   bit arV[NumMst], awV[NumMst], wV[NumMst];
   logic [IdWidth-1:0] arId[NumMst], awId[NumMst];
   logic [AddrWidth-1:0] arAddr[NumMst], awAddr[NumMst];
   logic [7:0] arLen[NumMst], awLen[NumMst];
   logic [AttrW-1:0] arAttr[NumMst], awAttr[NumMst];
   logic [DataWidth-1:0] wData[NumMst];
   logic [StrbW-1:0] wStrb[NumMst];
   int wLeft[NumMst];
   // Downstream-side driver state
   bit mrV, mbV, mrLast;
   logic [MIdW-1:0] mrId, mbId;
   logic [DataWidth-1:0] mrData;
   logic [1:0] mrResp, mbResp;
   bit mArReady, mAwReady, mWReady;
   logic [NumMst-1:0] sRReady, sBReady;

   // Model state. Grant indices use -1 for "none".
   int rrAr, rrAw, arHold, awHold, burst;
   int checks = 0, errors = 0;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int firstFrom(input logic [NumMst-1:0] v, input int ptr);
      for (int k = 0; k < NumMst; k++)
         if (v[(ptr + k) % NumMst]) return (ptr + k) % NumMst;
      return -1;
   endfunction

   task automatic applyStimulus();
      for (int i = 0; i < NumMst; i++) begin
         s_ar_valid_i[i] = arV[i];
         s_ar_id_i[i*IdWidth +: IdWidth] = arId[i];
         s_ar_addr_i[i*AddrWidth +: AddrWidth] = arAddr[i];
         s_ar_len_i[i*8 +: 8] = arLen[i];
         s_ar_attr_i[i*AttrW +: AttrW] = arAttr[i];
         s_aw_valid_i[i] = awV[i];
         s_aw_id_i[i*IdWidth +: IdWidth] = awId[i];
         s_aw_addr_i[i*AddrWidth +: AddrWidth] = awAddr[i];
         s_aw_len_i[i*8 +: 8] = awLen[i];
         s_aw_attr_i[i*AttrW +: AttrW] = awAttr[i];
         s_w_valid_i[i] = wV[i];
         s_w_data_i[i*DataWidth +: DataWidth] = wData[i];
         s_w_strb_i[i*StrbW +: StrbW] = wStrb[i];
         s_w_last_i[i] = (wLeft[i] == 1);
      end
      m_r_valid_i = mrV; m_r_id_i = mrId; m_r_data_i = mrData; m_r_resp_i = mrResp; m_r_last_i = mrLast;
      m_b_valid_i = mbV; m_b_id_i = mbId; m_b_resp_i = mbResp;
      m_ar_ready_i = mArReady; m_aw_ready_i = mAwReady; m_w_ready_i = mWReady;
      s_r_ready_i = sRReady; s_b_ready_i = sBReady;
   endtask

   task automatic clearDrivers();
      for (int i = 0; i < NumMst; i++) begin
         arV[i] = 0; awV[i] = 0; wV[i] = 0; wLeft[i] = 0;
         arId[i] = '0; awId[i] = '0; arAddr[i] = '0; awAddr[i] = '0;
         arLen[i] = '0; awLen[i] = '0; arAttr[i] = '0; awAttr[i] = '0;
         wData[i] = '0; wStrb[i] = '0;
      end
      mrV = 0; mbV = 0; mrLast = 0; mrId = '0; mbId = '0; mrData = '0; mrResp = '0; mbResp = '0;
      mArReady = 0; mAwReady = 0; mWReady = 0; sRReady = '0; sBReady = '0;
   endtask

   // One cycle of checking at the falling edge, followed by the model's
   // view of which handshakes complete at the next rising edge.
   task automatic checkCycle();
      int gAr, gAw, own, tag;
      logic [NumMst-1:0] vec;
      bit arHs, awHs, wHs, rHs, bHs, expW;
      @(negedge clk_i);
      if (rst_i) begin
         checkOutput("rst_m_ar_valid", 64'(m_ar_valid_o), 64'd0);
         checkOutput("rst_m_aw_valid", 64'(m_aw_valid_o), 64'd0);
         checkOutput("rst_m_w_valid", 64'(m_w_valid_o), 64'd0);
         checkOutput("rst_s_ar_ready", 64'(s_ar_ready_o), 64'd0);
         checkOutput("rst_s_aw_ready", 64'(s_aw_ready_o), 64'd0);
         checkOutput("rst_s_w_ready", 64'(s_w_ready_o), 64'd0);
         checkOutput("rst_s_r_valid", 64'(s_r_valid_o), 64'd0);
         checkOutput("rst_s_b_valid", 64'(s_b_valid_o), 64'd0);
         checkOutput("rst_m_r_ready", 64'(m_r_ready_o), 64'd0);
         checkOutput("rst_m_b_ready", 64'(m_b_ready_o), 64'd0);
         rrAr = 0; rrAw = 0; arHold = -1; awHold = -1; burst = -1;
         return;
      end
      for (int i = 0; i < NumMst; i++) vec[i] = arV[i];
      gAr = (arHold >= 0) ? arHold : firstFrom(vec, rrAr);
      checkOutput("m_ar_valid", 64'(m_ar_valid_o), 64'(gAr >= 0));
      if (gAr >= 0) begin
         checkOutput("m_ar_id", 64'(m_ar_id_o), (64'(gAr) << IdWidth) | 64'(arId[gAr]));
         checkOutput("m_ar_addr", m_ar_addr_o, arAddr[gAr]);
         checkOutput("m_ar_len", 64'(m_ar_len_o), 64'(arLen[gAr]));
         checkOutput("m_ar_attr", 64'(m_ar_attr_o), 64'(arAttr[gAr]));
      end
      for (int i = 0; i < NumMst; i++)
         if (arV[i]) checkOutput("s_ar_ready", 64'(s_ar_ready_o[i]), 64'(i == gAr && mArReady));
      arHs = (gAr >= 0) && mArReady;

      for (int i = 0; i < NumMst; i++) vec[i] = awV[i];
      gAw = (burst >= 0) ? -1 : (awHold >= 0) ? awHold : firstFrom(vec, rrAw);
      checkOutput("m_aw_valid", 64'(m_aw_valid_o), 64'(gAw >= 0));
      if (gAw >= 0) begin
         checkOutput("m_aw_id", 64'(m_aw_id_o), (64'(gAw) << IdWidth) | 64'(awId[gAw]));
         checkOutput("m_aw_addr", m_aw_addr_o, awAddr[gAw]);
         checkOutput("m_aw_len", 64'(m_aw_len_o), 64'(awLen[gAw]));
         checkOutput("m_aw_attr", 64'(m_aw_attr_o), 64'(awAttr[gAw]));
      end
      for (int i = 0; i < NumMst; i++)
         if (awV[i]) checkOutput("s_aw_ready", 64'(s_aw_ready_o[i]), 64'(i == gAw && mAwReady));
      awHs = (gAw >= 0) && mAwReady;

      own = burst;
      expW = (own >= 0) && wV[own];
      checkOutput("m_w_valid", 64'(m_w_valid_o), 64'(expW));
      if (expW) begin
         checkOutput("m_w_data", m_w_data_o, wData[own]);
         checkOutput("m_w_strb", 64'(m_w_strb_o), 64'(wStrb[own]));
         checkOutput("m_w_last", 64'(m_w_last_o), 64'(wLeft[own] == 1));
      end
      for (int i = 0; i < NumMst; i++)
         if (wV[i]) checkOutput("s_w_ready", 64'(s_w_ready_o[i]), 64'(i == own && mWReady));
      wHs = expW && mWReady;

      tag = int'(mrId[MIdW-1]);
      checkOutput("s_r_valid", 64'(s_r_valid_o), mrV ? (64'd1 << tag) : 64'd0);
      if (mrV) begin
         checkOutput("m_r_ready", 64'(m_r_ready_o), 64'(sRReady[tag]));
         checkOutput("s_r_id", 64'(s_r_id_o), 64'(mrId[IdWidth-1:0]));
         checkOutput("s_r_data", s_r_data_o, mrData);
         checkOutput("s_r_resp", 64'(s_r_resp_o), 64'(mrResp));
         checkOutput("s_r_last", 64'(s_r_last_o), 64'(mrLast));
      end
      rHs = mrV && sRReady[tag];

      tag = int'(mbId[MIdW-1]);
      checkOutput("s_b_valid", 64'(s_b_valid_o), mbV ? (64'd1 << tag) : 64'd0);
      if (mbV) begin
         checkOutput("m_b_ready", 64'(m_b_ready_o), 64'(sBReady[tag]));
         checkOutput("s_b_id", 64'(s_b_id_o), 64'(mbId[IdWidth-1:0]));
         checkOutput("s_b_resp", 64'(s_b_resp_o), 64'(mbResp));
      end
      bHs = mbV && sBReady[tag];

      if (arHs) begin rrAr = (gAr + 1) % NumMst; arHold = -1; arV[gAr] = 0; end
      else if (gAr >= 0) arHold = gAr;
      if (wHs) begin
         wV[own] = 0;
         wLeft[own]--;
         if (wLeft[own] == 0) burst = -1;
      end
      if (awHs) begin rrAw = (gAw + 1) % NumMst; awHold = -1; burst = gAw; awV[gAw] = 0; end
      else if (gAw >= 0) awHold = gAw;
      if (rHs) mrV = 0;
      if (bHs) mbV = 0;
   endtask

   task automatic advance(input bit rnd);
      @(posedge clk_i);
      #1;
      if (rnd) begin
         for (int i = 0; i < NumMst; i++) begin
            if (!arV[i] && ($urandom % 2 == 0)) begin
               arV[i] = 1; arId[i] = IdWidth'($urandom); arAddr[i] = {$urandom, $urandom};
               arLen[i] = 8'($urandom); arAttr[i] = AttrW'($urandom);
            end
            if (!awV[i] && wLeft[i] == 0 && ($urandom % 3 == 0)) begin
               awV[i] = 1; awId[i] = IdWidth'($urandom); awAddr[i] = {$urandom, $urandom};
               awLen[i] = 8'($urandom_range(0, 3)); awAttr[i] = AttrW'($urandom);
               wLeft[i] = int'(awLen[i]) + 1;
            end
            if (!wV[i] && wLeft[i] > 0 && ($urandom % 2 == 0)) begin
               wV[i] = 1; wData[i] = {$urandom, $urandom}; wStrb[i] = StrbW'($urandom);
            end
         end
         if (!mrV && ($urandom % 3 == 0)) begin
            mrV = 1; mrId = MIdW'($urandom); mrData = {$urandom, $urandom};
            mrResp = 2'($urandom); mrLast = 1'($urandom);
         end
         if (!mbV && ($urandom % 3 == 0)) begin
            mbV = 1; mbId = MIdW'($urandom); mbResp = 2'($urandom);
         end
         mArReady = ($urandom % 4) != 0;
         mAwReady = ($urandom % 4) != 0;
         mWReady  = ($urandom % 4) != 0;
         sRReady  = NumMst'($urandom);
         sBReady  = NumMst'($urandom);
      end
      applyStimulus();
   endtask

   initial begin
      // Reset with every input asserting valid/ready: nothing may leak out.
      clearDrivers();
      rst_i = 1'b1;
      for (int i = 0; i < NumMst; i++) begin arV[i] = 1; awV[i] = 1; wV[i] = 1; wLeft[i] = 1; end
      mrV = 1; mbV = 1; mArReady = 1; mAwReady = 1; mWReady = 1; sRReady = '1; sBReady = '1;
      applyStimulus();
      checkCycle();
      clearDrivers();
      applyStimulus();
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // AR round robin: both requesters use id 0x3, so the downstream ID is 0x03 or 0x13.
      mArReady = 1;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < NumMst; i++) begin arV[i] = 1; arId[i] = 4'h3; arAddr[i] = 64'(i + 100); end
         advance(0);
         checkCycle();
         checkOutput("ar_rr_id", 64'(m_ar_id_o), (k % 2 == 0) ? 64'h03 : 64'h13);
      end

      // AR hold: s0 is stalled for 3 cycles while s1 requests.
      arV[0] = 1; arAddr[0] = 64'hA000_0000_0000_0010; arV[1] = 0; arAddr[1] = 64'hB0;
      mArReady = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) arV[1] = 1;
         if (k == 3) mArReady = 1;
         advance(0);
         checkCycle();
         checkOutput("ar_hold_addr", m_ar_addr_o, 64'hA000_0000_0000_0010);
      end
      advance(0);
      checkCycle();
      checkOutput("ar_hold_next_tag", 64'(m_ar_id_o[MIdW-1]), 64'd1);
      mArReady = 0;

      // Response routing: R id 0x15 goes to s1, then B id 0x02 goes to s0.
      mrV = 1; mrId = 5'h15; mrData = 64'h1234_5678_9ABC_DEF0; mrLast = 1; sRReady = '1;
      advance(0);
      checkCycle();
      checkOutput("r_route_valid", 64'(s_r_valid_o), 64'h2);
      checkOutput("r_route_id", 64'(s_r_id_o), 64'h5);
      mbV = 1; mbId = 5'h02; sBReady = '1;
      advance(0);
      checkCycle();
      checkOutput("b_route_valid", 64'(s_b_valid_o), 64'h1);
      checkOutput("b_route_id", 64'(s_b_id_o), 64'h2);

      // Reset in the middle of a 4-beat burst from s0.
      awV[0] = 1; awId[0] = 4'h7; awLen[0] = 8'd3; wLeft[0] = 4; mAwReady = 1; mWReady = 1;
      advance(0);
      checkCycle();
      for (int k = 0; k < 2; k++) begin
         wV[0] = 1; wData[0] = {$urandom, $urandom}; wStrb[0] = 8'hFF;
         advance(0);
         checkCycle();
      end
      wV[0] = 1;
      advance(0);
      #1 checkOutput("burst_w_valid_pre_rst", 64'(m_w_valid_o), 64'd1);
      rst_i = 1'b1;
      #1 checkOutput("async_rst_w_valid", 64'(m_w_valid_o), 64'd0);
      checkOutput("async_rst_w_ready", 64'(s_w_ready_o), 64'd0);
      clearDrivers();
      applyStimulus();
      checkCycle();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      for (int i = 0; i < NumMst; i++) begin awV[i] = 1; awId[i] = IdWidth'(i + 1); awLen[i] = 0; wLeft[i] = 1; end
      mAwReady = 1;
      advance(0);
      checkCycle();
      checkOutput("aw_after_rst_tag", 64'(m_aw_id_o[MIdW-1]), 64'd0);

      // Randomized traffic on all channels.
      for (int n = 0; n < 3000; n++) begin
         advance(1);
         checkCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
